// File: rtl/key_repeat.sv
// Button auto-repeat: turns a debounced level into an initial press pulse,
// periodic repeat pulses while held, a release pulse and a long-hold level.
module key_repeat #(
  parameter int unsigned DELAY_TICKS = 500,
  parameter int unsigned RATE_TICKS  = 100,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned REP_W       = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             tick,
  input  logic             in,
  output logic             press,
  output logic             released,
  output logic             long,
  output logic [REP_W-1:0] rep_cnt
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);

  // Reject parameter sets the counter cannot represent.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("key_repeat: CNT_W must be in 1..31");
  end
  if (REP_W < 1) begin : g_bad_rep_w
    $error("key_repeat: REP_W must be at least 1");
  end
  if (DELAY_TICKS < 1 || longint'(DELAY_TICKS) > CNT_MAX) begin : g_bad_delay
    $error("key_repeat: DELAY_TICKS out of range 1..2^CNT_W-1");
  end
  if (RATE_TICKS < 1 || longint'(RATE_TICKS) > CNT_MAX) begin : g_bad_rate
    $error("key_repeat: RATE_TICKS out of range 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Saturating repeat counter value for the next auto-repeat.
  logic [REP_W-1:0] rep_next_c;
  assign rep_next_c = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + REP_W'(1);

  // Single-block FSM; pulses default low so each lasts one clk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= '0;
      press    <= 1'b0;
      released <= 1'b0;
      long     <= 1'b0;
      rep_cnt  <= '0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      case (state)
        IDLE: begin
          if (in) begin
            state   <= HOLD;
            cnt     <= '0;
            press   <= 1'b1;
            rep_cnt <= '0;
          end
        end
        HOLD: begin
          if (!in) begin
            state    <= IDLE;
            cnt      <= '0;
            released <= 1'b1;
            long     <= 1'b0;
          end else if (tick) begin
            if (cnt == DELAY_LAST) begin
              state   <= REPEAT;
              cnt     <= '0;
              press   <= 1'b1;
              long    <= 1'b1;
              rep_cnt <= rep_next_c;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!in) begin
            state    <= IDLE;
            cnt      <= '0;
            released <= 1'b1;
            long     <= 1'b0;
          end else if (tick) begin
            if (cnt == RATE_LAST) begin
              cnt     <= '0;
              press   <= 1'b1;
              rep_cnt <= rep_next_c;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          long  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: two instances (normal and saturating) driven by the
// same stimulus, checked every clk against a tick-counting model.
module tb_key_repeat;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       tick = 1'b0;
  logic       in = 1'b0;
  logic       press0, rel0, long0;
  logic [7:0] rep0;
  logic       press1, rel1, long1;
  logic [1:0] rep1;

  always #5 clk = ~clk;

  key_repeat #(.DELAY_TICKS(3), .RATE_TICKS(2), .CNT_W(10), .REP_W(8)) dut0 (
    .clk(clk), .nreset(nreset), .tick(tick), .in(in),
    .press(press0), .released(rel0), .long(long0), .rep_cnt(rep0)
  );

  key_repeat #(.DELAY_TICKS(3), .RATE_TICKS(1), .CNT_W(4), .REP_W(2)) dut1 (
    .clk(clk), .nreset(nreset), .tick(tick), .in(in),
    .press(press1), .released(rel1), .long(long1), .rep_cnt(rep1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count ticks seen since the initial press; a repeat falls on tick
  // number DELAY, DELAY+RATE, DELAY+2*RATE, ...
  int delay_p[2] = '{3, 3};
  int rate_p[2]  = '{2, 1};
  int rmax_p[2]  = '{255, 3};
  bit m_hold[2], m_press[2], m_rel[2], m_long[2];
  int m_k[2], m_rep[2];

  always @(posedge clk or negedge nreset) begin
    for (int d = 0; d < 2; d++) begin
      if (!nreset) begin
        m_hold[d] = 0; m_press[d] = 0; m_rel[d] = 0; m_long[d] = 0;
        m_k[d] = 0; m_rep[d] = 0;
      end else begin
        m_press[d] = 0;
        m_rel[d]   = 0;
        if (!m_hold[d]) begin
          if (in) begin
            m_hold[d] = 1; m_k[d] = 0; m_press[d] = 1; m_rep[d] = 0;
          end
        end else if (!in) begin
          m_hold[d] = 0; m_rel[d] = 1; m_long[d] = 0;
        end else if (tick) begin
          m_k[d]++;
          if (m_k[d] >= delay_p[d] && (m_k[d] - delay_p[d]) % rate_p[d] == 0) begin
            m_press[d] = 1;
            m_long[d]  = 1;
            if (m_rep[d] < rmax_p[d]) m_rep[d]++;
          end
        end
      end
    end
  end

  bit cmp_en = 0;
  int press_cnt0 = 0, rel_cnt0 = 0, long_seen0 = 0;
  int press_cnt1 = 0, rel_cnt1 = 0;

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dut0 press", int'(press0), int'(m_press[0]));
      check("dut0 release", int'(rel0), int'(m_rel[0]));
      check("dut0 long", int'(long0), int'(m_long[0]));
      check("dut0 rep_cnt", int'(rep0), m_rep[0]);
      check("dut1 press", int'(press1), int'(m_press[1]));
      check("dut1 release", int'(rel1), int'(m_rel[1]));
      check("dut1 long", int'(long1), int'(m_long[1]));
      check("dut1 rep_cnt", int'(rep1), m_rep[1]);
      if (press0) press_cnt0++;
      if (rel0) rel_cnt0++;
      if (long0) long_seen0++;
      if (press1) press_cnt1++;
      if (rel1) rel_cnt1++;
    end
  end

  int cyc = 0;

  task automatic step(input logic i, input logic t);
    in   = i;
    tick = t;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // period 0: no ticks; otherwise tick on every period-th clk.
  task automatic run(input logic i, input int n, input int period);
    for (int j = 0; j < n; j++)
      step(i, (period != 0) && (cyc % period == period - 1));
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    press_cnt0 = 0; rel_cnt0 = 0; long_seen0 = 0;
    press_cnt1 = 0; rel_cnt1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset press", int'(press0), 0);
    check("reset release", int'(rel0), 0);
    check("reset long", int'(long0), 0);
    check("reset rep_cnt", int'(rep0), 0);
    nreset = 1'b1;
    run(0, 4, 4);

    // Short press
    clear_counts();
    run(1, 6, 4);
    run(0, 3, 4);
    settle();
    check("short press count", press_cnt0, 1);
    check("short release count", rel_cnt0, 1);
    check("short long seen", long_seen0, 0);
    check("short rep_cnt", int'(rep0), 0);

    // Long hold
    clear_counts();
    run(1, 40, 4);
    settle();
    check("long hold long", int'(long0), 1);
    check("long hold rep_cnt", int'(rep0), 4);
    check("long hold press count", press_cnt0, 5);
    run(0, 3, 4);
    settle();
    check("long hold release count", rel_cnt0, 1);
    check("long hold long after", int'(long0), 0);
    check("long hold rep_cnt held", int'(rep0), 4);

    // Release coincides with the terminal tick
    clear_counts();
    step(1, 0);
    step(1, 1); step(1, 0); step(1, 1); step(1, 0);
    step(0, 1);
    step(0, 0); step(0, 0);
    settle();
    check("collision press count", press_cnt0, 1);
    check("collision release count", rel_cnt0, 1);
    check("collision long seen", long_seen0, 0);
    check("collision rep_cnt", int'(rep0), 0);

    // Saturation with tick every clk
    clear_counts();
    run(1, 20, 1);
    settle();
    check("sat rep_cnt", int'(rep1), 3);
    check("sat press count", press_cnt1, 18);
    check("sat long", int'(long1), 1);
    check("sat dut0 rep_cnt", int'(rep0), 9);
    run(0, 3, 1);
    settle();
    check("sat release count", rel_cnt1, 1);

    // Asynchronous reset in REPEAT
    clear_counts();
    run(1, 20, 4);
    settle();
    check("areset long before", int'(long0), 1);
    #1 nreset = 1'b0;
    #1;
    check("areset press", int'(press0), 0);
    check("areset release", int'(rel0), 0);
    check("areset long", int'(long0), 0);
    check("areset rep_cnt", int'(rep0), 0);
    check("areset dut1 long", int'(long1), 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
    check("areset new press", int'(press0), 1);
    check("areset no release", int'(rel0), 0);
    settle();
    check("areset release count", rel_cnt0, 0);
    run(0, 3, 4);

    // Idle ticks
    clear_counts();
    run(0, 50, 1);
    settle();
    check("idle press count", press_cnt0 + press_cnt1, 0);
    check("idle release count", rel_cnt0 + rel_cnt1, 0);
    check("idle long seen", long_seen0, 0);
    check("idle rep_cnt", int'(rep0) + int'(rep1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
